control_unit: RTL and testbench
===============================

# control_unit

Hardwired Moore control sequencer driving the single-bus CPU datapath. Each state is one clock. The block steps through the fetch sequence (T0–T2), decodes the 5-bit opcode in `IR[31:27]`, and runs the execute states for the supported instruction subset. Memory-access states stall on a `mem_ready` handshake. The block replaces hand-driven control-signal sequencing in datapath benches.

## Interface
- No parameters. Opcode and state encodings are fixed constants (see Structure).
- `clk` in 1: single clock. All state changes occur on the rising edge.
- `clear_n` in 1: synchronous, active-low reset.
- `IR` in 32: instruction register contents from the datapath.
- `mem_ready` in 1: memory completed the current Read/Write this cycle.
- `PCout Zlowout MDRout Cout HIout LOout BAout Rout` out 1 each: bus drive selects.
- `PCin MARin Zin MDRin IRin Yin HIin LOin Rin` out 1 each: register load enables.
- `Gra Grb Grc IncPC Read Write` out 1 each: register select, PC increment, memory strobes.
- `ADD SUB AND OR SHR SHL ROR ROL NEG NOT` out 1 each: ALU op, one-hot or all-zero.
- `clear` out 1: active-high datapath clear.
- `Run` out 1: low only in HALT.
- `illegal` out 1: one-cycle pulse when an unsupported opcode is decoded.

## Operation
- Opcodes:
  - `ld` 00000, `ldi` 00001, `st` 00010
  - `add` 00011, `sub` 00100, `shr` 00101, `shl` 00110, `ror` 00111, `rol` 01000, `and` 01001, `or` 01010
  - `addi` 01011, `andi` 01100, `ori` 01101
  - `neg` 10001, `not` 10010
  - `mfhi` 11000, `mflo` 11001
  - `nop` 11010, `halt` 11011
- Any other opcode: `illegal` pulses, then the block returns to T0.
- States: RST, T0–T7, HALT (4-bit).
- Fetch:
  - T0: PCout MARin IncPC Zin.
  - T1: Zlowout PCin Read MDRin.
  - T2: MDRout IRin.
- Reg ALU (`add`…`or`):
  - T3: Grb Rout Yin.
  - T4: Grc Rout op Zin.
  - T5: Zlowout Gra Rin.
- Immediate (`addi andi ori`): as Reg ALU, except T4 is Cout op Zin. `addi` uses ADD, `andi` uses AND, `ori` uses OR.
- `neg`/`not`:
  - T3: Grb Rout op Zin.
  - T4: Zlowout Gra Rin.
- `mfhi`/`mflo`: T3 only: Gra Rin HIout/LOout.
- `ld`:
  - T3: Grb BAout Yin.
  - T4: Cout ADD Zin.
  - T5: Zlowout MARin.
  - T6: Read MDRin.
  - T7: MDRout Gra Rin.
- `ldi`: T3–T4 as `ld`; T5: Zlowout Gra Rin.
- `st`:
  - T3–T5 as `ld`.
  - T6: Gra Rout MDRin (Read=0, so MDR loads from the bus).
  - T7: Write.
- `nop`: T2 → T0.
- `halt`: T2 → HALT. HALT holds with all strobes 0 and Run=0 until reset.
- The last execute state of every instruction returns to T0.

## Timing
- Outputs are a pure decode of the registered state (plus `IR` opcode in T3+). They are stable for the whole cycle and consumed by datapath registers at the next rising edge.
- `clear_n`=0 at an edge → state RST, regardless of current state, including mid-instruction or mid-stall.
- In RST:
  - clear=1, Run=1, illegal=0, all other outputs 0.
  - The first edge with `clear_n`=1 moves RST → T0.
- Stalls:
  - T1 and `ld` T6 hold, with outputs unchanged, while `mem_ready`=0.
  - `st` T7 holds with Write=1 while `mem_ready`=0.
  - Advance occurs on the edge where `mem_ready`=1. Minimum stay is one cycle.
- Latencies with zero-wait memory, T0 to next T0:
  - Reg/imm ALU 6 cycles, neg/not 5, mfhi/mflo 4, nop 3.
  - ld 8, ldi 6, st 8.
- Exactly one ALU op line is high in any state that asserts Zin, except T0. T0 relies on IncPC, and all op lines are 0 there.
- `mem_ready` is ignored outside stall states.
- `IR` is sampled only in T3 onward, so it must hold stable from the T2 edge.

## Structure
- `control_defs.vh`: opcode localparams, state localparams, and the op-class encoding (ALU_R, ALU_I, UNARY, MOVE, LD, LDI, ST, NOP, HALT, ILLEGAL).
- Sub-module `op_decode`: combinational opcode → class plus one-hot ALU-op vector.
- Top level holds the state register and the output decode.

## Test plan
- Reset and fetch:
  - Stimulus: hold clear_n=0 for 2 cycles, then release.
  - Required: clear=1 and all strobes 0 during reset; T0 asserts PCout/MARin/IncPC/Zin one cycle after release.
- `add` r1,r2,r3, IR=0x18918000, mem_ready=1:
  - T4 asserts Grc Rout ADD Zin.
  - T5 asserts Zlowout Gra Rin.
  - Back to T0 six cycles after the previous T0.
- `mflo` r5, IR=0xCA800000:
  - T3 asserts Gra LOout Rin only.
  - Next cycle is T0.
- `ld` r1,0x55(r0), IR=0x00800055, mem_ready held 0 for 3 cycles in T6:
  - T6 persists 4 cycles with Read=MDRin=1.
  - T7 asserts MDRout Gra Rin.
- `st`, IR=0x10800055, mem_ready=0 for 2 cycles in T7:
  - Write is held for 3 cycles.
  - Reset pulsed during the stall forces RST with Write=0 at the next edge.
- Exceptional opcodes:
  - IR=0xD8000000 (`halt`) → Run=0 and all strobes 0 for 10 or more cycles.
  - IR=0x78000000 (opcode 01111) → `illegal` high for exactly one cycle, then T0.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared encodings for the single-bus CPU control sequencer:
// opcodes, sequencer states, opcode classes, ALU op lines and the strobe bundle.
package control_unit_pkg;

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_e;

    typedef enum logic [3:0] {
        CLS_ALU_R   = 4'd0,
        CLS_ALU_I   = 4'd1,
        CLS_UNARY   = 4'd2,
        CLS_MOVE    = 4'd3,
        CLS_LD      = 4'd4,
        CLS_LDI     = 4'd5,
        CLS_ST      = 4'd6,
        CLS_NOP     = 4'd7,
        CLS_HALT    = 4'd8,
        CLS_ILLEGAL = 4'd9
    } op_class_e;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // One-hot ALU op lines, bit order {NOT,NEG,ROL,ROR,SHL,SHR,OR,AND,SUB,ADD}
    localparam logic [9:0] ALU_NONE = 10'b0000000000;
    localparam logic [9:0] ALU_ADD  = 10'b0000000001;
    localparam logic [9:0] ALU_SUB  = 10'b0000000010;
    localparam logic [9:0] ALU_AND  = 10'b0000000100;
    localparam logic [9:0] ALU_OR   = 10'b0000001000;
    localparam logic [9:0] ALU_SHR  = 10'b0000010000;
    localparam logic [9:0] ALU_SHL  = 10'b0000100000;
    localparam logic [9:0] ALU_ROR  = 10'b0001000000;
    localparam logic [9:0] ALU_ROL  = 10'b0010000000;
    localparam logic [9:0] ALU_NEG  = 10'b0100000000;
    localparam logic [9:0] ALU_NOT  = 10'b1000000000;

    typedef struct packed {
        logic PCout;
        logic Zlowout;
        logic MDRout;
        logic Cout;
        logic HIout;
        logic LOout;
        logic BAout;
        logic Rout;
        logic PCin;
        logic MARin;
        logic Zin;
        logic MDRin;
        logic IRin;
        logic Yin;
        logic HIin;
        logic LOin;
        logic Rin;
        logic Gra;
        logic Grb;
        logic Grc;
        logic IncPC;
        logic Read;
        logic Write;
        logic [9:0] aluOp;
        logic clear;
        logic Run;
        logic illegal;
    } ctrl_t;

endpackage

// File: rtl/control_unit_op_decode.sv
// Combinational opcode classifier: maps IR[31:27] to an instruction class,
// the one-hot ALU op used by its execute states, and the HI/LO move select.
module op_decode
    import control_unit_pkg::*;
(
    input  logic [4:0] i_opcode,
    output op_class_e  o_class,
    output logic [9:0] o_aluOp,
    output logic       o_moveHi
);

    always_comb begin
        o_class  = CLS_ILLEGAL;
        o_aluOp  = ALU_NONE;
        o_moveHi = 1'b0;
        case (i_opcode)
            OP_LD:   begin o_class = CLS_LD;    o_aluOp = ALU_ADD; end
            OP_LDI:  begin o_class = CLS_LDI;   o_aluOp = ALU_ADD; end
            OP_ST:   begin o_class = CLS_ST;    o_aluOp = ALU_ADD; end
            OP_ADD:  begin o_class = CLS_ALU_R; o_aluOp = ALU_ADD; end
            OP_SUB:  begin o_class = CLS_ALU_R; o_aluOp = ALU_SUB; end
            OP_SHR:  begin o_class = CLS_ALU_R; o_aluOp = ALU_SHR; end
            OP_SHL:  begin o_class = CLS_ALU_R; o_aluOp = ALU_SHL; end
            OP_ROR:  begin o_class = CLS_ALU_R; o_aluOp = ALU_ROR; end
            OP_ROL:  begin o_class = CLS_ALU_R; o_aluOp = ALU_ROL; end
            OP_AND:  begin o_class = CLS_ALU_R; o_aluOp = ALU_AND; end
            OP_OR:   begin o_class = CLS_ALU_R; o_aluOp = ALU_OR;  end
            OP_ADDI: begin o_class = CLS_ALU_I; o_aluOp = ALU_ADD; end
            OP_ANDI: begin o_class = CLS_ALU_I; o_aluOp = ALU_AND; end
            OP_ORI:  begin o_class = CLS_ALU_I; o_aluOp = ALU_OR;  end
            OP_NEG:  begin o_class = CLS_UNARY; o_aluOp = ALU_NEG; end
            OP_NOT:  begin o_class = CLS_UNARY; o_aluOp = ALU_NOT; end
            OP_MFHI: begin o_class = CLS_MOVE;  o_moveHi = 1'b1;   end
            OP_MFLO: begin o_class = CLS_MOVE;  end
            OP_NOP:  begin o_class = CLS_NOP;   end
            OP_HALT: begin o_class = CLS_HALT;  end
            default: begin o_class = CLS_ILLEGAL; end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the single-bus CPU datapath:
// fetch T0-T2, opcode-dependent execute states T3-T7, memory stalls and HALT.
module control_unit
    import control_unit_pkg::*;
(
    input  logic        clk,
    input  logic        clear_n,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Cout,
    output logic        HIout,
    output logic        LOout,
    output logic        BAout,
    output logic        Rout,
    output logic        PCin,
    output logic        MARin,
    output logic        Zin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        Rin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        ADD,
    output logic        SUB,
    output logic        AND,
    output logic        OR,
    output logic        SHR,
    output logic        SHL,
    output logic        ROR,
    output logic        ROL,
    output logic        NEG,
    output logic        NOT,
    output logic        clear,
    output logic        Run,
    output logic        illegal
);

    state_e    r_state;
    state_e    w_nextState;
    op_class_e w_class;
    logic [9:0] w_aluOp;
    logic      w_moveHi;
    ctrl_t     w_ctrl;
    logic      w_unusedIrBits;

    // Operand/immediate fields are consumed by the datapath, not the sequencer
    assign w_unusedIrBits = ^IR[26:0];

    op_decode u_opDecode (
        .i_opcode (IR[31:27]),
        .o_class  (w_class),
        .o_aluOp  (w_aluOp),
        .o_moveHi (w_moveHi)
    );

    always_ff @(posedge clk) begin
        if (!clear_n) r_state <= S_RST;
        else          r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_RST: w_nextState = S_T0;
            S_T0:  w_nextState = S_T1;
            S_T1:  w_nextState = mem_ready ? S_T2 : S_T1;
            S_T2: begin
                case (w_class)
                    CLS_NOP:  w_nextState = S_T0;
                    CLS_HALT: w_nextState = S_HALT;
                    default:  w_nextState = S_T3;
                endcase
            end
            S_T3: begin
                case (w_class)
                    CLS_ALU_R, CLS_ALU_I, CLS_UNARY,
                    CLS_LD, CLS_LDI, CLS_ST: w_nextState = S_T4;
                    default:                 w_nextState = S_T0;
                endcase
            end
            S_T4: begin
                case (w_class)
                    CLS_ALU_R, CLS_ALU_I,
                    CLS_LD, CLS_LDI, CLS_ST: w_nextState = S_T5;
                    default:                 w_nextState = S_T0;
                endcase
            end
            S_T5: w_nextState = (w_class == CLS_LD || w_class == CLS_ST) ? S_T6 : S_T0;
            S_T6: begin
                case (w_class)
                    CLS_LD:  w_nextState = mem_ready ? S_T7 : S_T6;
                    CLS_ST:  w_nextState = S_T7;
                    default: w_nextState = S_T0;
                endcase
            end
            S_T7: begin
                if (w_class == CLS_ST) w_nextState = mem_ready ? S_T0 : S_T7;
                else                   w_nextState = S_T0;
            end
            S_HALT:  w_nextState = S_HALT;
            default: w_nextState = S_RST;
        endcase
    end

    // Run stays high everywhere except HALT; op lines only where Zin loads a result
    always_comb begin
        w_ctrl     = '0;
        w_ctrl.Run = 1'b1;
        case (r_state)
            S_RST: w_ctrl.clear = 1'b1;
            S_T0: begin
                w_ctrl.PCout = 1'b1; w_ctrl.MARin = 1'b1;
                w_ctrl.IncPC = 1'b1; w_ctrl.Zin   = 1'b1;
            end
            S_T1: begin
                w_ctrl.Zlowout = 1'b1; w_ctrl.PCin  = 1'b1;
                w_ctrl.Read    = 1'b1; w_ctrl.MDRin = 1'b1;
            end
            S_T2: begin
                w_ctrl.MDRout = 1'b1; w_ctrl.IRin = 1'b1;
            end
            S_T3: begin
                case (w_class)
                    CLS_ALU_R, CLS_ALU_I: begin
                        w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.Yin = 1'b1;
                    end
                    CLS_UNARY: begin
                        w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1;
                        w_ctrl.aluOp = w_aluOp; w_ctrl.Zin = 1'b1;
                    end
                    CLS_MOVE: begin
                        w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1;
                        w_ctrl.HIout = w_moveHi; w_ctrl.LOout = ~w_moveHi;
                    end
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        w_ctrl.Grb = 1'b1; w_ctrl.BAout = 1'b1; w_ctrl.Yin = 1'b1;
                    end
                    CLS_ILLEGAL: w_ctrl.illegal = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                case (w_class)
                    CLS_ALU_R: begin
                        w_ctrl.Grc = 1'b1; w_ctrl.Rout = 1'b1;
                        w_ctrl.aluOp = w_aluOp; w_ctrl.Zin = 1'b1;
                    end
                    CLS_ALU_I, CLS_LD, CLS_LDI, CLS_ST: begin
                        w_ctrl.Cout = 1'b1; w_ctrl.aluOp = w_aluOp; w_ctrl.Zin = 1'b1;
                    end
                    CLS_UNARY: begin
                        w_ctrl.Zlowout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (w_class)
                    CLS_ALU_R, CLS_ALU_I, CLS_LDI: begin
                        w_ctrl.Zlowout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        w_ctrl.Zlowout = 1'b1; w_ctrl.MARin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (w_class)
                    CLS_LD: begin
                        w_ctrl.Read = 1'b1; w_ctrl.MDRin = 1'b1;
                    end
                    CLS_ST: begin
                        w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.MDRin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (w_class)
                    CLS_LD: begin
                        w_ctrl.MDRout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1;
                    end
                    CLS_ST:  w_ctrl.Write = 1'b1;
                    default: ;
                endcase
            end
            S_HALT:  w_ctrl.Run = 1'b0;
            default: w_ctrl.clear = 1'b1;
        endcase
    end

    assign PCout   = w_ctrl.PCout;
    assign Zlowout = w_ctrl.Zlowout;
    assign MDRout  = w_ctrl.MDRout;
    assign Cout    = w_ctrl.Cout;
    assign HIout   = w_ctrl.HIout;
    assign LOout   = w_ctrl.LOout;
    assign BAout   = w_ctrl.BAout;
    assign Rout    = w_ctrl.Rout;
    assign PCin    = w_ctrl.PCin;
    assign MARin   = w_ctrl.MARin;
    assign Zin     = w_ctrl.Zin;
    assign MDRin   = w_ctrl.MDRin;
    assign IRin    = w_ctrl.IRin;
    assign Yin     = w_ctrl.Yin;
    assign HIin    = w_ctrl.HIin;
    assign LOin    = w_ctrl.LOin;
    assign Rin     = w_ctrl.Rin;
    assign Gra     = w_ctrl.Gra;
    assign Grb     = w_ctrl.Grb;
    assign Grc     = w_ctrl.Grc;
    assign IncPC   = w_ctrl.IncPC;
    assign Read    = w_ctrl.Read;
    assign Write   = w_ctrl.Write;
    assign ADD     = w_ctrl.aluOp[0];
    assign SUB     = w_ctrl.aluOp[1];
    assign AND     = w_ctrl.aluOp[2];
    assign OR      = w_ctrl.aluOp[3];
    assign SHR     = w_ctrl.aluOp[4];
    assign SHL     = w_ctrl.aluOp[5];
    assign ROR     = w_ctrl.aluOp[6];
    assign ROL     = w_ctrl.aluOp[7];
    assign NEG     = w_ctrl.aluOp[8];
    assign NOT     = w_ctrl.aluOp[9];
    assign clear   = w_ctrl.clear;
    assign Run     = w_ctrl.Run;
    assign illegal = w_ctrl.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: each task walks one instruction
// cycle by cycle and compares the full strobe vector against hand-built values.
module tb_control_unit;

    logic        clk;
    logic        clear_n;
    logic [31:0] IR;
    logic        mem_ready;

    logic PCout, Zlowout, MDRout, Cout, HIout, LOout, BAout, Rout;
    logic PCin, MARin, Zin, MDRin, IRin, Yin, HIin, LOin, Rin;
    logic Gra, Grb, Grc, IncPC, Read, Write;
    logic ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT;
    logic clear, Run, illegal;

    int checks = 0;
    int errors = 0;

    control_unit dut (
        .clk(clk), .clear_n(clear_n), .IR(IR), .mem_ready(mem_ready),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout),
        .HIout(HIout), .LOout(LOout), .BAout(BAout), .Rout(Rout),
        .PCin(PCin), .MARin(MARin), .Zin(Zin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .HIin(HIin), .LOin(LOin), .Rin(Rin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write),
        .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .SHR(SHR), .SHL(SHL),
        .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT),
        .clear(clear), .Run(Run), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [35:0] obs = {PCout, Zlowout, MDRout, Cout, HIout, LOout, BAout, Rout,
                       PCin, MARin, Zin, MDRin, IRin, Yin, HIin, LOin, Rin,
                       Gra, Grb, Grc, IncPC, Read, Write,
                       ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT,
                       clear, Run, illegal};

    localparam logic [35:0] M_PCout   = 36'd1 << 35;
    localparam logic [35:0] M_Zlowout = 36'd1 << 34;
    localparam logic [35:0] M_MDRout  = 36'd1 << 33;
    localparam logic [35:0] M_Cout    = 36'd1 << 32;
    localparam logic [35:0] M_LOout   = 36'd1 << 30;
    localparam logic [35:0] M_BAout   = 36'd1 << 29;
    localparam logic [35:0] M_Rout    = 36'd1 << 28;
    localparam logic [35:0] M_PCin    = 36'd1 << 27;
    localparam logic [35:0] M_MARin   = 36'd1 << 26;
    localparam logic [35:0] M_Zin     = 36'd1 << 25;
    localparam logic [35:0] M_MDRin   = 36'd1 << 24;
    localparam logic [35:0] M_IRin    = 36'd1 << 23;
    localparam logic [35:0] M_Yin     = 36'd1 << 22;
    localparam logic [35:0] M_Rin     = 36'd1 << 19;
    localparam logic [35:0] M_Gra     = 36'd1 << 18;
    localparam logic [35:0] M_Grb     = 36'd1 << 17;
    localparam logic [35:0] M_Grc     = 36'd1 << 16;
    localparam logic [35:0] M_IncPC   = 36'd1 << 15;
    localparam logic [35:0] M_Read    = 36'd1 << 14;
    localparam logic [35:0] M_Write   = 36'd1 << 13;
    localparam logic [35:0] M_ADD     = 36'd1 << 12;
    localparam logic [35:0] M_clear   = 36'd1 << 2;
    localparam logic [35:0] M_Run     = 36'd1 << 1;
    localparam logic [35:0] M_illegal = 36'd1 << 0;

    localparam logic [35:0] E_RST   = M_clear | M_Run;
    localparam logic [35:0] E_T0    = M_PCout | M_MARin | M_IncPC | M_Zin | M_Run;
    localparam logic [35:0] E_T1    = M_Zlowout | M_PCin | M_Read | M_MDRin | M_Run;
    localparam logic [35:0] E_T2    = M_MDRout | M_IRin | M_Run;
    localparam logic [35:0] E_RR_T3 = M_Grb | M_Rout | M_Yin | M_Run;
    localparam logic [35:0] E_RR_T4 = M_Grc | M_Rout | M_ADD | M_Zin | M_Run;
    localparam logic [35:0] E_WB    = M_Zlowout | M_Gra | M_Rin | M_Run;
    localparam logic [35:0] E_MFLO  = M_Gra | M_Rin | M_LOout | M_Run;
    localparam logic [35:0] E_LD_T3 = M_Grb | M_BAout | M_Yin | M_Run;
    localparam logic [35:0] E_LD_T4 = M_Cout | M_ADD | M_Zin | M_Run;
    localparam logic [35:0] E_LD_T5 = M_Zlowout | M_MARin | M_Run;
    localparam logic [35:0] E_LD_T6 = M_Read | M_MDRin | M_Run;
    localparam logic [35:0] E_LD_T7 = M_MDRout | M_Gra | M_Rin | M_Run;
    localparam logic [35:0] E_ST_T6 = M_Gra | M_Rout | M_MDRin | M_Run;
    localparam logic [35:0] E_ST_T7 = M_Write | M_Run;
    localparam logic [35:0] E_HALT  = 36'd0;
    localparam logic [35:0] E_ILL   = M_illegal | M_Run;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_n   = 1'b0;
        mem_ready = 1'b1;
        IR        = 32'h0;
        tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (obs !== E_RST) begin
                errors++;
                $display("[TB] FAIL reset cycle %0d: got %h expected %h", i, obs, E_RST);
            end
            if (i == 1) clear_n = 1'b1;
            tick();
        end
        #1;
        checks++;
        if (obs !== E_T0) begin
            errors++;
            $display("[TB] FAIL reset_release_T0: got %h expected %h", obs, E_T0);
        end
    endtask

    task automatic test_add();
        logic [35:0] expv [7];
        expv = '{E_T0, E_T1, E_T2, E_RR_T3, E_RR_T4, E_WB, E_T0};
        IR = 32'h18918000;
        mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1;
            checks++;
            if (obs !== expv[i]) begin
                errors++;
                $display("[TB] FAIL add step %0d: got %h expected %h", i, obs, expv[i]);
            end
            if (i < 6) tick();
        end
    endtask

    task automatic test_mflo();
        logic [35:0] expv [5];
        expv = '{E_T0, E_T1, E_T2, E_MFLO, E_T0};
        IR = 32'hCA800000;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (obs !== expv[i]) begin
                errors++;
                $display("[TB] FAIL mflo step %0d: got %h expected %h", i, obs, expv[i]);
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_nop();
        logic [35:0] expv [4];
        expv = '{E_T0, E_T1, E_T2, E_T0};
        IR = 32'hD0000000;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (obs !== expv[i]) begin
                errors++;
                $display("[TB] FAIL nop step %0d: got %h expected %h", i, obs, expv[i]);
            end
            if (i < 3) tick();
        end
    endtask

    // T6 is entered at step 6; mem_ready is withheld for three cycles there
    task automatic test_ld_stall();
        logic [35:0] expv [12];
        logic        mr   [12];
        expv = '{E_T0, E_T1, E_T2, E_LD_T3, E_LD_T4, E_LD_T5,
                 E_LD_T6, E_LD_T6, E_LD_T6, E_LD_T6, E_LD_T7, E_T0};
        mr   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        IR = 32'h00800055;
        for (int i = 0; i < 12; i++) begin
            mem_ready = mr[i];
            #1;
            checks++;
            if (obs !== expv[i]) begin
                errors++;
                $display("[TB] FAIL ld_stall step %0d: got %h expected %h", i, obs, expv[i]);
            end
            if (i < 11) tick();
        end
        mem_ready = 1'b1;
    endtask

    // First pass completes after a two-cycle stall; second pass is reset mid-stall
    task automatic test_st_stall_reset();
        logic [35:0] expv [11];
        logic        mr   [11];
        logic        cn   [11];
        expv = '{E_T0, E_T1, E_T2, E_LD_T3, E_LD_T4, E_LD_T5,
                 E_ST_T6, E_ST_T7, E_ST_T7, E_ST_T7, E_T0};
        mr   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        IR = 32'h10800055;
        clear_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            mem_ready = mr[i];
            #1;
            checks++;
            if (obs !== expv[i]) begin
                errors++;
                $display("[TB] FAIL st_stall step %0d: got %h expected %h", i, obs, expv[i]);
            end
            if (i < 10) tick();
        end
        expv = '{E_T0, E_T1, E_T2, E_LD_T3, E_LD_T4, E_LD_T5,
                 E_ST_T6, E_ST_T7, E_ST_T7, E_RST, E_T0};
        mr   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        cn   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 11; i++) begin
            mem_ready = mr[i];
            clear_n   = cn[i];
            #1;
            checks++;
            if (obs !== expv[i]) begin
                errors++;
                $display("[TB] FAIL st_reset step %0d: got %h expected %h", i, obs, expv[i]);
            end
            if (i < 10) tick();
        end
        mem_ready = 1'b1;
    endtask

    // Twelve HALT cycles with mem_ready toggling, then a reset to leave HALT
    task automatic test_halt();
        logic [35:0] expv [17];
        IR = 32'hD8000000;
        for (int i = 0; i < 17; i++) expv[i] = E_HALT;
        expv[0]  = E_T0;
        expv[1]  = E_T1;
        expv[2]  = E_T2;
        expv[15] = E_RST;
        expv[16] = E_T0;
        for (int i = 0; i < 17; i++) begin
            mem_ready = (i < 3 || i > 14) ? 1'b1 : i[0];
            clear_n   = (i == 14) ? 1'b0 : 1'b1;
            #1;
            checks++;
            if (obs !== expv[i]) begin
                errors++;
                $display("[TB] FAIL halt step %0d: got %h expected %h", i, obs, expv[i]);
            end
            if (i < 16) tick();
        end
        clear_n   = 1'b1;
        mem_ready = 1'b1;
    endtask

    task automatic test_illegal();
        logic [35:0] expv [6];
        expv = '{E_T0, E_T1, E_T2, E_ILL, E_T0, E_T1};
        IR = 32'h78000000;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (obs !== expv[i]) begin
                errors++;
                $display("[TB] FAIL illegal step %0d: got %h expected %h", i, obs, expv[i]);
            end
            if (i < 5) tick();
        end
    endtask

    initial begin
        clear_n   = 1'b0;
        IR        = 32'h0;
        mem_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_add();
        test_mflo();
        test_nop();
        test_ld_stall();
        test_st_stall_reset();
        test_halt();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
